truth_table_checker: RTL and testbench
======================================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles per row between driving inputs and sampling f (legal 0..15).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a sweep; honoured only in IDLE.
REQ-005 SHALL have port expected  input  16  golden truth table; bit i = required f for row i.
REQ-006 SHALL have port f_in  input  1  response of the function under test.
REQ-007 SHALL have ports a, b, c, d  output  1 each  row stimulus; {a,b,c,d} = row index, a is MSB.
REQ-008 SHALL have port busy  output  1  high from start acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-010 SHALL have port pass  output  1  high when observed equals latched expected.
REQ-011 SHALL have port observed  output  16  captured f per row.
REQ-012 SHALL have port fail_count  output  5  number of mismatching rows, 0..16.
REQ-013 SHALL have port first_fail  output  4  lowest mismatching row index; valid only when fail_count != 0.

Function
REQ-014 SHALL implement FSM IDLE -> DRIVE -> SAMPLE -> (DRIVE for next row | DONE) -> IDLE.
REQ-015 IDLE: start=1 at an edge SHALL latch expected, clear observed/fail_count/first_fail/pass, set row=0, enter DRIVE; busy high from next cycle.
REQ-016 DRIVE SHALL hold {a,b,c,d}=row for SETTLE_CYCLES cycles (zero cycles when SETTLE_CYCLES=0), then enter SAMPLE.
REQ-017 SAMPLE SHALL last one cycle with {a,b,c,d}=row held, write f_in into observed[row], and on mismatch increment fail_count and, if first mismatch, load first_fail=row.
REQ-018 Each row SHALL occupy exactly SETTLE_CYCLES+1 cycles; row 0 drive starts the cycle after start is accepted.
REQ-019 After SAMPLE of row 15, row SHALL NOT wrap to 0; FSM enters DONE, done=1 for one cycle, pass=(fail_count==0) registered, busy drops with done.
REQ-020 Done SHALL occur 16*(SETTLE_CYCLES+1)+1 cycles after the start-accepting edge (49 for default).
REQ-021 start asserted while busy or in DONE SHALL be ignored; no restart, no result change.
REQ-022 In IDLE, {a,b,c,d} SHALL be 4'b0000; results SHALL hold until next accepted start.
REQ-023 Changes on expected after start acceptance SHALL NOT affect the current sweep.
REQ-024 fail_count SHALL not saturate below 16; all-16 mismatch reports 5'd16.
REQ-025 start held high continuously SHALL begin a new sweep on the first cycle back in IDLE.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE from any state, including mid-sweep, abandoning the sweep.
REQ-027 After reset: a=b=c=d=0, busy=0, done=0, pass=0, observed=16'h0000, fail_count=0, first_fail=0, latched expected=0.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 Package truth_table_pkg SHALL hold the FSM state enum (IDLE, DRIVE, SAMPLE, DONE), N_IN=4, N_ROWS=16 and row-index/count widths.
REQ-030 Sub-module settle_timer (loadable down-counter, SETTLE_CYCLES reload, expired flag) SHALL time DRIVE; all else in one module.

Verification
REQ-031 expected=16'hA5A5, behavioural model matches, SETTLE_CYCLES=2 -> done 49 cycles after start, pass=1, observed=16'hA5A5, fail_count=0.
REQ-032 Same, model flips row 6 -> observed=16'hA5E5, fail_count=1, first_fail=6, pass=0.
REQ-033 Model f stuck-at-0, expected=16'hA5A5 -> observed=16'h0000, fail_count=8, first_fail=0, pass=0; stuck-at-1 against 16'h0000 -> fail_count=16.
REQ-034 reset pulsed during row 9 -> next cycle IDLE, all outputs at reset values; fresh start completes normally.
REQ-035 start re-pulsed during row 3, expected changed mid-sweep -> single done at original time, results reflect original expected.
REQ-036 SETTLE_CYCLES=0, combinational model -> done 17 cycles after start, each row stimulus visible exactly one cycle, pass=1.

Source files
------------

// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared definitions for the truth-table checker.
//   N_IN     - number of stimulus inputs (a, b, c, d)
//   N_ROWS   - rows in the exhaustive sweep
//   ROW_W    - width of a row index
//   FCNT_W   - width of the mismatch counter (must hold N_ROWS itself)
//   SETTLE_W - width of the settle timer (SETTLE_CYCLES legal range 0..15)
//   state_t  - sweep controller states
package truth_table_pkg;

  localparam int N_IN     = 4;
  localparam int N_ROWS   = 1 << N_IN;
  localparam int ROW_W    = N_IN;
  localparam int FCNT_W   = $clog2(N_ROWS + 1);
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that times the DRIVE phase of a row.
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset
//   load    - reload the counter for a new DRIVE phase
//   enable  - count down (asserted while in DRIVE)
//   expired - high on the last DRIVE cycle of the row
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  // Loading SETTLE_CYCLES-1 makes the terminal count coincide with the
  // final DRIVE cycle, so DRIVE lasts exactly SETTLE_CYCLES cycles.
  localparam int RELOAD_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(RELOAD_I);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (enable && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all 16 input combinations of a 4-input
// function, captures its response per row and compares against a golden
// truth table latched at start.
//   clock      - rising-edge clock
//   reset      - synchronous active-high reset
//   start      - request a sweep (honoured only in IDLE)
//   expected   - golden truth table, bit i = required f for row i
//   f_in       - response of the function under test
//   a,b,c,d    - row stimulus, {a,b,c,d} = row index (a is MSB)
//   busy       - sweep in progress
//   done       - one-cycle pulse at sweep end
//   pass       - observed matched latched expected on the last sweep
//   observed   - captured f per row
//   fail_count - number of mismatching rows (0..16)
//   first_fail - lowest mismatching row (meaningful when fail_count != 0)
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [N_ROWS-1:0]   expected,
  input  logic                f_in,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_ROWS-1:0]   observed,
  output logic [FCNT_W-1:0]   fail_count,
  output logic [ROW_W-1:0]    first_fail
);

  // With no settle time a row is a lone SAMPLE cycle; DRIVE is skipped.
  localparam bit               NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(N_ROWS - 1);

  state_t state, state_next;

  logic [ROW_W-1:0]  row;
  logic [N_ROWS-1:0] expected_q;

  logic timer_load;
  logic timer_en;
  logic timer_expired;
  logic accept;
  logic sampling;
  logic drive_row;
  logic finish;
  logic last_row;
  logic mismatch;

  assign last_row = (row == LAST_ROW);
  assign mismatch = f_in ^ expected_q[row];

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = NO_SETTLE ? SAMPLE : DRIVE;
        end
      end
      DRIVE: begin
        if (timer_expired) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_row) begin
          state_next = DONE;
        end else begin
          state_next = NO_SETTLE ? SAMPLE : DRIVE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    accept     = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    sampling   = 1'b0;
    drive_row  = 1'b0;
    finish     = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        accept     = start;
        timer_load = start;
      end
      DRIVE: begin
        timer_en  = 1'b1;
        drive_row = 1'b1;
      end
      SAMPLE: begin
        sampling   = 1'b1;
        drive_row  = 1'b1;
        timer_load = ~last_row;
      end
      DONE: begin
        finish = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Stimulus is parked at zero outside the active rows (IDLE and DONE).
  assign {a, b, c, d} = drive_row ? row : '0;

  // Result datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      expected_q <= '0;
      row        <= '0;
      observed   <= '0;
      fail_count <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // done is registered off DONE, so it rises together with busy falling.
      done <= finish;

      if (accept) begin
        expected_q <= expected;
        row        <= '0;
        observed   <= '0;
        fail_count <= '0;
        first_fail <= '0;
        pass       <= 1'b0;
      end

      if (sampling) begin
        observed[row] <= f_in;
        if (mismatch) begin
          fail_count <= fail_count + FCNT_W'(1);
          if (fail_count == '0) begin
            first_fail <= row;
          end
        end
        // Row stays at 15 after the last sample rather than wrapping.
        if (!last_row) begin
          row <= row + ROW_W'(1);
        end
      end

      if (finish) begin
        pass <= (fail_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam int S2 = 2;
  localparam int S0 = 0;

  typedef struct {
    int          done_cyc;
    logic [15:0] obs;
    int          fc;
    int          ff;
    logic        pass;
  } item_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  int   cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Unit with SETTLE_CYCLES = 2
  logic        start2 = 1'b0;
  logic [15:0] exp2   = '0;
  logic [15:0] fut2   = '0;
  logic        f2;
  logic        a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] obs2;
  logic [4:0]  fc2;
  logic [3:0]  ff2;

  // Unit with SETTLE_CYCLES = 0
  logic        start0 = 1'b0;
  logic [15:0] exp0   = '0;
  logic [15:0] fut0   = '0;
  logic        f0;
  logic        a0, b0, c0, d0, busy0, done0, pass0;
  logic [15:0] obs0;
  logic [4:0]  fc0;
  logic [3:0]  ff0;

  // Behavioural function under test: a lookup of its own truth table.
  assign f2 = fut2[{a2, b2, c2, d2}];
  assign f0 = fut0[{a0, b0, c0, d0}];

  truth_table_checker #(.SETTLE_CYCLES(S2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .expected(exp2), .f_in(f2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .observed(obs2), .fail_count(fc2), .first_fail(ff2)
  );

  truth_table_checker #(.SETTLE_CYCLES(S0)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .expected(exp0), .f_in(f0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .observed(obs0), .fail_count(fc0), .first_fail(ff0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  item_t sb2[$];
  item_t sb0[$];
  int    base2 = -1;
  int    base0 = -1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference: results follow directly from the set of differing rows.
  function automatic item_t model(input logic [15:0] expv, input logic [15:0] futv, input int dcyc);
    item_t it;
    logic [15:0] diff;
    diff        = expv ^ futv;
    it.done_cyc = dcyc;
    it.obs      = futv;
    it.fc       = $countones(diff);
    it.ff       = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) it.ff = i;
    it.pass     = (diff == 16'h0000);
    return it;
  endfunction

  function automatic int qsize(input int u);
    return (u == 2) ? sb2.size() : sb0.size();
  endfunction

  // Monitors: per-cycle row stimulus inside a sweep, and scoreboard at done.
  always @(negedge clock) begin
    item_t it;
    if (!reset) begin
      if (base2 >= 0 && (cyc - base2) < 16 * (S2 + 1)) begin
        check("u2_row", {a2, b2, c2, d2}, (cyc - base2) / (S2 + 1));
        check("u2_busy", busy2, 1);
      end
      if (done2) begin
        if (sb2.size() == 0) begin
          check("u2_spurious_done", done2, 0);
        end else begin
          it = sb2.pop_front();
          check("u2_done_cycle", cyc, it.done_cyc);
          check("u2_observed", obs2, it.obs);
          check("u2_fail_count", fc2, it.fc);
          if (it.fc != 0) check("u2_first_fail", ff2, it.ff);
          check("u2_pass", pass2, it.pass);
          check("u2_busy_at_done", busy2, 0);
          base2 = -1;
        end
      end
    end
  end

  always @(negedge clock) begin
    item_t it;
    if (!reset) begin
      if (base0 >= 0 && (cyc - base0) < 16 * (S0 + 1)) begin
        check("u0_row", {a0, b0, c0, d0}, (cyc - base0) / (S0 + 1));
        check("u0_busy", busy0, 1);
      end
      if (done0) begin
        if (sb0.size() == 0) begin
          check("u0_spurious_done", done0, 0);
        end else begin
          it = sb0.pop_front();
          check("u0_done_cycle", cyc, it.done_cyc);
          check("u0_observed", obs0, it.obs);
          check("u0_fail_count", fc0, it.fc);
          if (it.fc != 0) check("u0_first_fail", ff0, it.ff);
          check("u0_pass", pass0, it.pass);
          check("u0_busy_at_done", busy0, 0);
          base0 = -1;
        end
      end
    end
  end

  task automatic drain(input int u);
    int k = 0;
    while (qsize(u) != 0 && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (qsize(u) != 0) begin
      n_checks++;
      $display("FAIL done_timeout: unit %0d still waiting on %0d sweeps", u, qsize(u));
      if (u == 2) begin sb2.delete(); base2 = -1; end
      else begin sb0.delete(); base0 = -1; end
    end
  endtask

  task automatic run_sweep(input int u, input logic [15:0] expv, input logic [15:0] futv);
    @(negedge clock);
    if (u == 2) begin exp2 = expv; fut2 = futv; start2 = 1'b1; end
    else begin exp0 = expv; fut0 = futv; start0 = 1'b1; end
    @(negedge clock);
    if (u == 2) begin
      start2 = 1'b0;
      base2  = cyc;
      sb2.push_back(model(expv, futv, cyc + 16 * (S2 + 1) + 1));
    end else begin
      start0 = 1'b0;
      base0  = cyc;
      sb0.push_back(model(expv, futv, cyc + 16 * (S0 + 1) + 1));
    end
    drain(u);
  endtask

  task automatic check_reset();
    check("rst_u2_abcd", {a2, b2, c2, d2}, 0);
    check("rst_u2_busy", busy2, 0);
    check("rst_u2_done", done2, 0);
    check("rst_u2_pass", pass2, 0);
    check("rst_u2_observed", obs2, 0);
    check("rst_u2_fail_count", fc2, 0);
    check("rst_u2_first_fail", ff2, 0);
    check("rst_u0_abcd", {a0, b0, c0, d0}, 0);
    check("rst_u0_busy", busy0, 0);
    check("rst_u0_pass", pass0, 0);
    check("rst_u0_observed", obs0, 0);
    check("rst_u0_fail_count", fc0, 0);
  endtask

  function automatic logic [15:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h0001 << $urandom_range(0, 15);
      2:       return 16'($urandom);
      default: return 16'hFFFF;
    endcase
  endfunction

  initial begin
    logic [15:0] e;
    int b;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset();

    // Directed cases at the default settle time
    run_sweep(2, 16'hA5A5, 16'hA5A5);
    run_sweep(2, 16'hA5A5, 16'hA5E5);
    run_sweep(2, 16'hA5A5, 16'h0000);
    run_sweep(2, 16'h0000, 16'hFFFF);

    // Randomized sweeps
    for (int i = 0; i < 6; i++) begin
      e = 16'($urandom);
      run_sweep(2, e, e ^ rand_mask());
    end

    // start re-pulsed and expected changed during row 3
    @(negedge clock);
    exp2 = 16'hA5A5; fut2 = 16'hA5A5; start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    b = cyc;
    base2 = b;
    sb2.push_back(model(16'hA5A5, 16'hA5A5, b + 49));
    while (cyc < b + 10) @(negedge clock);
    start2 = 1'b1;
    exp2 = 16'hFFFF;
    @(negedge clock);
    start2 = 1'b0;
    drain(2);
    repeat (60) @(negedge clock);

    // Reset during row 9 abandons the sweep
    @(negedge clock);
    exp2 = 16'h1234; fut2 = 16'h4321; start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    b = cyc;
    base2 = b;
    sb2.push_back(model(16'h1234, 16'h4321, b + 49));
    while (cyc < b + 27) @(negedge clock);
    base2 = -1;
    sb2.delete();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset();
    repeat (60) @(negedge clock);
    run_sweep(2, 16'hA5A5, 16'hA5A5);

    // start held high: second sweep begins on the first IDLE cycle
    @(negedge clock);
    exp2 = 16'h0F0F; fut2 = 16'h0F1F; start2 = 1'b1;
    @(negedge clock);
    b = cyc;
    sb2.push_back(model(16'h0F0F, 16'h0F1F, b + 49));
    sb2.push_back(model(16'h0F0F, 16'h0F1F, b + 50 + 49));
    while (cyc < b + 50) @(negedge clock);
    start2 = 1'b0;
    drain(2);

    // Zero settle time: one cycle per row
    run_sweep(0, 16'hA5A5, 16'hA5A5);
    run_sweep(0, 16'hA5A5, 16'hA5E5);
    run_sweep(0, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      e = 16'($urandom);
      run_sweep(0, e, e ^ rand_mask());
    end

    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
